// File: rtl/jtsdram_bank.sv
// SDRAM bank self-test: LFSR-addressed read (or write-then-read) checks against a
// known address-derived pattern, with pass/fail counters and a per-request timeout.
module jtsdram_bank #(
    parameter int          WRITE_EN = 0,
    parameter logic [21:0] SEED     = 22'h2A_5A5A,
    parameter int          TOUT     = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [21:0] addr,
    output logic        rd,
    output logic        wr,
    output logic [15:0] din,
    output logic [1:0]  din_m,
    input  logic        ack,
    input  logic        rdy,
    input  logic [31:0] data_read,
    output logic        busy,
    output logic        err,
    output logic [7:0]  err_cnt,
    output logic [15:0] ok_cnt
);

    localparam int TW = $clog2(TOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TOUT - 1);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CHECK} state_t;

    function automatic logic [15:0] pattern(input logic [21:0] a);
        return a[15:0] ^ {10'd0, a[21:16]};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

    state_t         state;
    logic [21:0]    lfsr;
    logic [TW-1:0]  tcnt;
    logic [31:0]    data_p1;

    logic           req_st;
    logic           wait_st;
    logic           rdy_seen;
    logic           tout_hit;
    logic           pass;
    logic [21:0]    lfsr_nx;
    logic [21:0]    next_addr;

    assign req_st    = (state == WR_REQ) || (state == RD_REQ);
    assign wait_st   = (state == WR_WAIT) || (state == RD_WAIT);
    // In a request state rdy only counts when it arrives together with ack
    assign rdy_seen  = rdy && (wait_st || (req_st && ack));
    assign tout_hit  = (req_st || wait_st) && !rdy_seen && (tcnt == TLAST);
    assign lfsr_nx   = {lfsr[20:0], lfsr[21] ^ lfsr[20]};
    assign next_addr = {lfsr[21:1], 1'b0};
    assign pass      = (data_p1[15:0] == pattern(addr)) &&
                       ((WRITE_EN != 0) || (data_p1[31:16] == pattern(addr + 22'd1)));

    // Read capture stage: data is only consumed in CHECK, so it needs no reset
    always_ff @(posedge clk) begin
        if (rdy_seen && ((state == RD_REQ) || (state == RD_WAIT)))
            data_p1 <= data_read;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            lfsr    <= SEED;
            addr    <= '0;
            rd      <= 1'b0;
            wr      <= 1'b0;
            din     <= '0;
            din_m   <= 2'b11;
            busy    <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
            ok_cnt  <= '0;
            tcnt    <= '0;
        end else if (tout_hit) begin
            state   <= IDLE;
            rd      <= 1'b0;
            wr      <= 1'b0;
            din_m   <= 2'b11;
            busy    <= 1'b0;
            err     <= 1'b0 | 1'b1;
            err_cnt <= sat_inc(err_cnt);
            lfsr    <= lfsr_nx;
        end else begin
            if (req_st || wait_st)
                tcnt <= tcnt + 1'b1;
            case (state)
                IDLE: if (en) begin
                    addr <= next_addr;
                    busy <= 1'b1;
                    tcnt <= '0;
                    if (WRITE_EN != 0) begin
                        state <= WR_REQ;
                        wr    <= 1'b1;
                        din   <= pattern(next_addr);
                        din_m <= 2'b00;
                    end else begin
                        state <= RD_REQ;
                        rd    <= 1'b1;
                    end
                end
                WR_REQ: if (ack) begin
                    wr    <= 1'b0;
                    din_m <= 2'b11;
                    if (rdy) begin
                        state <= RD_REQ;
                        rd    <= 1'b1;
                        tcnt  <= '0;
                    end else begin
                        state <= WR_WAIT;
                    end
                end
                WR_WAIT: if (rdy) begin
                    state <= RD_REQ;
                    rd    <= 1'b1;
                    tcnt  <= '0;
                end
                RD_REQ: if (ack) begin
                    rd    <= 1'b0;
                    state <= rdy ? CHECK : RD_WAIT;
                end
                RD_WAIT: if (rdy)
                    state <= CHECK;
                CHECK: begin
                    if (pass) begin
                        ok_cnt <= ok_cnt + 16'd1;
                    end else begin
                        err     <= 1'b1;
                        err_cnt <= sat_inc(err_cnt);
                    end
                    lfsr  <= lfsr_nx;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/jtsdram_bank.md
JTSDRAM_BANK -- requirements
Module: jtsdram_bank

Interface
REQ-001 Parameter WRITE_EN, default 0: 1 = write-then-read test (bank 0 only); 0 = read-only test.
REQ-002 Parameter SEED, default 22'h2A_5A5A: nonzero LFSR seed.
REQ-003 Parameter TOUT, default 255: cycles allowed from request to rdy.
REQ-004 clk  in  1  system clock, 48/96 MHz SDRAM domain; one clock only.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 en  in  1  run enable: new transactions start only while high.
REQ-007 addr  out  22  bank word address to SDRAM controller.
REQ-008 rd  out  1  read request.
REQ-009 wr  out  1  write request; constant 0 when WRITE_EN=0.
REQ-010 din  out  16  write data.
REQ-011 din_m  out  2  write byte mask, 1 = byte not written.
REQ-012 ack  in  1  controller accepted request.
REQ-013 rdy  in  1  read data valid / write complete.
REQ-014 data_read  in  32  read data: [15:0] = word at addr, [31:16] = word at addr+1.
REQ-015 busy  out  1  high while a transaction is open.
REQ-016 err  out  1  sticky error flag.
REQ-017 err_cnt  out  8  error count, saturating.
REQ-018 ok_cnt  out  16  passed-check count, wrapping.

Function
REQ-019 Pattern P(a) = a[15:0] ^ {10'd0, a[21:16]}; ROM download preloads read-only banks with P.
REQ-020 Address source: 22-bit Fibonacci LFSR, taps 22,21, advanced once per completed transaction; addr = {lfsr[21:1],1'b0} (even only).
REQ-021 FSM states IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CHECK.
REQ-022 IDLE: if en, latch addr, go WR_REQ when WRITE_EN=1 else RD_REQ; busy=1 from next cycle.
REQ-023 WR_REQ: wr=1, din=P(addr), din_m=2'b00 held until ack; cycle after ack: wr=0, go WR_WAIT.
REQ-024 WR_WAIT: on rdy go RD_REQ.
REQ-025 RD_REQ: rd=1 held until ack; cycle after ack: rd=0, go RD_WAIT.
REQ-026 RD_WAIT: on rdy register data_read, go CHECK.
REQ-027 ack and rdy in the same cycle in a REQ state: treated as ack then immediate rdy; no extra wait state.
REQ-028 CHECK (1 cycle): pass when data_read[15:0]==P(addr) and, if WRITE_EN=0, data_read[31:16]==P(addr+1); pass -> ok_cnt+1; fail -> err=1, err_cnt+1 (saturate at 255); advance LFSR; go IDLE.
REQ-029 Timeout: counter cleared on entry to each REQ state; if rdy not seen within TOUT cycles, drop rd/wr, count as failure, advance LFSR, go IDLE.
REQ-030 en low mid-transaction: current transaction completes normally; IDLE then holds.
REQ-031 Outside REQ states rd=wr=0; din, addr hold last value; din_m=2'b11.
REQ-032 rdy outside WAIT states ignored.

Reset
REQ-033 rst_n low at a rising edge: state IDLE, lfsr=SEED, addr=0, rd=0, wr=0, din=0, din_m=2'b11, busy=0, err=0, err_cnt=0, ok_cnt=0.
REQ-034 Reset mid-transaction aborts immediately; rd/wr low in the first cycle after the reset edge.
REQ-035 err clears only by reset.

Verification
REQ-036 Reset then en=1, WRITE_EN=0, model returns P words after 4 cycles -> rd drops cycle after ack, ok_cnt increments once per transaction, err=0, addr follows LFSR.
REQ-037 Model corrupts data_read[31:16] once -> err=1, err_cnt=1, ok_cnt unchanged for that transaction, test continues.
REQ-038 WRITE_EN=1 -> wr with din=P(addr), din_m=00, then rd at same addr; model echo -> pass.
REQ-039 Model never asserts rdy -> after TOUT=255 cycles rd=0, err_cnt=1, next transaction at next LFSR address.
REQ-040 en dropped during RD_WAIT -> transaction finishes, busy falls, no further rd; 300 errors forced -> err_cnt stays 255.
REQ-041 rst_n low during RD_REQ -> next cycle rd=0, all counters 0, addr=0, lfsr=SEED.
